imem_loader: RTL and testbench

Boot-time instruction-memory loader: the write side of the CPU's instruction memory, which the fetch stage only reads. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes them to sequential IMEM addresses and holds the CPU pipeline in reset until a frame passes its checksum. It sits between the host/UART byte source and the IMEM write port, beside the cpu top level.

---
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader (framed byte stream to IMEM writes)
//
// Purpose:
//   Receives a framed byte stream and assembles big-endian 16-bit words.
//   Frame: SYNC_BYTE, COUNT, COUNT x {HI, LO}, CKSUM. A COUNT of 0 means DEPTH words.
//   The words are written to consecutive IMEM addresses starting at 0.
//   The CPU pipeline is held in reset until a frame passes its XOR checksum.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   in_data       stream byte
//   in_valid      in_data is valid
//   in_ready      byte accepted this cycle (low only in the WRITE cycle)
//   wr_en         IMEM write strobe, one cycle per word
//   wr_addr       IMEM write address
//   wr_data       IMEM write data, low INSTR_WIDTH bits of {HI, LO}
//   cpu_hold      keeps the CPU pipeline in reset while high
//   done          last frame loaded with a good checksum
//   error         last frame failed its checksum
//   words_loaded  words written in the current or last frame
//
// INSTR_WIDTH must not exceed 16.

module imem_loader #(
    parameter int         INSTR_WIDTH   = 16,
    parameter int         ADDR_WIDTH    = 8,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter bit         HOLD_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH:0]    words_loaded
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CKSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0] target_words;
    logic [CNT_W-1:0] words_inc;
    logic [CNT_W-1:0] count_words;
    logic [7:0]       hi_byte;
    logic [7:0]       csum;
    logic [15:0]      word_nx;
    logic             xfer;
    logic             last_word;
    logic             csum_ok;

    // in_ready depends only on state, so it never forms a loop through
    // the upstream valid logic. WRITE is the single bubble cycle.
    assign in_ready  = (state != S_WRITE);
    assign xfer      = in_valid & in_ready;

    assign words_inc = words_loaded + CNT_W'(1);
    assign last_word = (words_inc == target_words);
    assign word_nx   = {hi_byte, in_data};
    assign csum_ok   = (in_data == csum);

    // COUNT == 0 requests a full-depth load.
    assign count_words = (in_data == 8'h00) ? CNT_W'(DEPTH) : CNT_W'(in_data);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        case (state)
            // DONE and ERR only differ from IDLE by the status flags they
            // leave behind; all three hunt for the next sync byte.
            S_IDLE, S_DONE, S_ERR: begin
                if (xfer && (in_data == SYNC_BYTE)) begin
                    state_nx = S_COUNT;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    state_nx = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    state_nx = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en    = 1'b1;
                state_nx = last_word ? S_CKSUM : S_HI;
            end
            S_CKSUM: begin
                if (xfer) begin
                    state_nx = csum_ok ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_words <= '0;
            hi_byte      <= '0;
            csum         <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= HOLD_ON_RESET;
        end else begin
            case (state)
                S_COUNT: begin
                    if (xfer) begin
                        target_words <= count_words;
                        wr_addr      <= '0;
                        words_loaded <= '0;
                        csum         <= in_data;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_hold     <= 1'b1;
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        hi_byte <= in_data;
                        csum    <= csum ^ in_data;
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        wr_data <= word_nx[INSTR_WIDTH-1:0];
                        csum    <= csum ^ in_data;
                    end
                end
                S_WRITE: begin
                    // Address wraps naturally at DEPTH; the count is one bit
                    // wider so a full-depth frame ends at DEPTH.
                    wr_addr      <= wr_addr + ADDR_WIDTH'(1);
                    words_loaded <= words_inc;
                end
                S_CKSUM: begin
                    // The checksum byte is compared, never folded in.
                    // Words already written stay in IMEM on a mismatch.
                    if (xfer) begin
                        if (csum_ok) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error    <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    imem_loader #(
        .INSTR_WIDTH  (16),
        .ADDR_WIDTH   (8),
        .SYNC_BYTE    (8'hA5),
        .HOLD_ON_RESET(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic        vin;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        dn;
        logic        er;
        logic        hold;
        logic [8:0]  wl;
    } vec_t;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef wr_t        wr_q_t[$];
    typedef logic [7:0] byte_q_t[$];

    int     checks = 0;
    int     errors = 0;
    int     rdy_bad = 0;
    bit     rnd = 1'b0;
    wr_q_t  wlog;
    wr_q_t  basic_exp;
    vec_t   tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write log and in_ready/WRITE-cycle correspondence, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (wr_en) wlog.push_back({wr_addr, wr_data});
            if (in_ready == wr_en) rdy_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int g;
        if (rnd) begin
            int n;
            n = $urandom_range(0, 2);
            repeat (n) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 8) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck low for byte %0h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t q);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic check_log(input string name, input wr_q_t exp);
        int bad;
        bad = 0;
        check({name, " write count"}, wlog.size(), exp.size());
        for (int i = 0; i < wlog.size() && i < exp.size(); i++) begin
            if (wlog[i] !== exp[i]) begin
                if (bad == 0)
                    $display("FAIL %s write %0d: got %0h expected %0h", name, i, wlog[i], exp[i]);
                bad++;
            end
        end
        check({name, " write entries bad"}, bad, 0);
    endtask

    task automatic check_status(input string name, input logic dn, input logic er,
                                input logic hold, input logic [8:0] wl, input logic [7:0] addr);
        check({name, " done"},         done,         dn);
        check({name, " error"},        error,        er);
        check({name, " cpu_hold"},     cpu_hold,     hold);
        check({name, " words_loaded"}, words_loaded, wl);
        check({name, " wr_addr"},      wr_addr,      addr);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, " in_ready"},     in_ready,     1);
        check({name, " wr_en"},        wr_en,        0);
        check({name, " wr_addr"},      wr_addr,      0);
        check({name, " wr_data"},      wr_data,      0);
        check({name, " done"},         done,         0);
        check({name, " error"},        error,        0);
        check({name, " cpu_hold"},     cpu_hold,     1);
        check({name, " words_loaded"}, words_loaded, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t bq;
        wr_q_t   eq;

        basic_exp.push_back({8'h00, 16'h1234});
        basic_exp.push_back({8'h01, 16'hABCD});

        // Basic load, cycle by cycle: {din, vin, rdy, we, addr, data, done, err, hold, wl}
        // checksum = 02^12^34^AB^CD = 42
        tbl[0]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 9'd0};
        tbl[1]  = '{8'h02, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 9'd0};
        tbl[2]  = '{8'h12, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 9'd0};
        tbl[3]  = '{8'h34, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 9'd0};
        tbl[4]  = '{8'h34, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 9'd0};
        tbl[5]  = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h00, 16'h1234, 1'b0, 1'b0, 1'b1, 9'd0};
        tbl[6]  = '{8'hAB, 1'b1, 1'b1, 1'b0, 8'h01, 16'h1234, 1'b0, 1'b0, 1'b1, 9'd1};
        tbl[7]  = '{8'hCD, 1'b1, 1'b1, 1'b0, 8'h01, 16'h1234, 1'b0, 1'b0, 1'b1, 9'd1};
        tbl[8]  = '{8'h77, 1'b1, 1'b0, 1'b1, 8'h01, 16'hABCD, 1'b0, 1'b0, 1'b1, 9'd1};
        tbl[9]  = '{8'h42, 1'b1, 1'b1, 1'b0, 8'h02, 16'hABCD, 1'b0, 1'b0, 1'b1, 9'd2};
        tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 16'hABCD, 1'b1, 1'b0, 1'b0, 9'd2};
        tbl[11] = '{8'h42, 1'b0, 1'b1, 1'b0, 8'h02, 16'hABCD, 1'b1, 1'b0, 1'b0, 9'd2};

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            check($sformatf("vec%0d in_ready", i),     in_ready,     tbl[i].rdy);
            check($sformatf("vec%0d wr_en", i),        wr_en,        tbl[i].we);
            check($sformatf("vec%0d wr_addr", i),      wr_addr,      tbl[i].addr);
            check($sformatf("vec%0d wr_data", i),      wr_data,      tbl[i].data);
            check($sformatf("vec%0d done", i),         done,         tbl[i].dn);
            check($sformatf("vec%0d error", i),        error,        tbl[i].er);
            check($sformatf("vec%0d cpu_hold", i),     cpu_hold,     tbl[i].hold);
            check($sformatf("vec%0d words_loaded", i), words_loaded, tbl[i].wl);
            in_data  = tbl[i].din;
            in_valid = tbl[i].vin;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_log("basic", basic_exp);

        // Bad checksum: words stay written, error set, CPU stays held
        wlog.delete();
        bq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
        send_bytes(bq);
        check_log("badck", basic_exp);
        check_status("badck", 1'b0, 1'b1, 1'b1, 9'd2, 8'h02);

        // Leading garbage with random valid gaps
        wlog.delete();
        rdy_bad = 0;
        rnd = 1'b1;
        bq = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_bytes(bq);
        rnd = 1'b0;
        check_log("resync", basic_exp);
        check_status("resync", 1'b1, 1'b0, 1'b0, 9'd2, 8'h02);
        check("resync in_ready vs WRITE", rdy_bad, 0);

        // Full depth: COUNT=0, word i = i; XOR of 0..255 is 0
        wlog.delete();
        eq.delete();
        bq = '{8'hA5, 8'h00};
        for (int i = 0; i < 256; i++) begin
            bq.push_back(8'h00);
            bq.push_back(8'(i));
            eq.push_back({8'(i), 16'(i)});
        end
        bq.push_back(8'h00);
        send_bytes(bq);
        check_log("full", eq);
        check_status("full", 1'b1, 1'b0, 1'b0, 9'd256, 8'h00);

        // Asynchronous reset after the HI byte of word 1
        bq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB};
        send_bytes(bq);
        wlog.delete();
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("async_rst no write", wlog.size(), 0);
        check_reset_vals("after_rst");
        bq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_bytes(bq);
        check_log("post_rst", basic_exp);
        check_status("post_rst", 1'b1, 1'b0, 1'b0, 9'd2, 8'h02);

        // Reload after DONE: flags change only after the COUNT handshake
        wlog.delete();
        send_byte(8'hA5);
        check("reload pre-count done", done, 1);
        check("reload pre-count cpu_hold", cpu_hold, 0);
        send_byte(8'h01);
        check("reload post-count done", done, 0);
        check("reload post-count cpu_hold", cpu_hold, 1);
        bq = '{8'hBE, 8'hEF, 8'h50};   // 01^BE^EF = 50
        send_bytes(bq);
        eq.delete();
        eq.push_back({8'h00, 16'hBEEF});
        check_log("reload", eq);
        check_status("reload", 1'b1, 1'b0, 1'b0, 9'd1, 8'h01);
        check("overall in_ready vs WRITE", rdy_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
